// File: rtl/fir_sample_feeder.sv
// Sample-rate pacing FIFO feeding the binary FIR: releases one buffered sample per PERIOD cycles.
// Define FIR_FEEDER_HOLD_ON_UNDERRUN_EN to hold the last sample on underrun instead of inserting zero.
module fir_sample_feeder #(
    parameter int W      = 13,
    parameter int PERIOD = 4096,
    parameter int DEPTH  = 8,
    parameter int CNT_W  = 12
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       enable,
    input  logic [W-1:0]               s_data,
    input  logic                       s_valid,
    output logic                       s_ready,
    output logic [W-1:0]               sample,
    output logic                       sample_stb,
    output logic [$clog2(DEPTH):0]     fifo_level,
    output logic                       underrun,
    output logic [15:0]                sample_count
);

    // state | meaning
    // IDLE  | paused; counter held at 0, no strobes
    // PRIME | enabled, waiting for the first buffered sample
    // RUN   | pacing; boundary every PERIOD cycles

    localparam int AW = $clog2(DEPTH);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] PRIME = 2'd1;
    localparam logic [1:0] RUN   = 2'd2;

    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(PERIOD - 1);
    localparam logic [AW:0]      FULL   = (AW + 1)'(DEPTH);

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [CNT_W-1:0] count;
    logic [W-1:0]     mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push;
    logic             pop;
    logic             fifo_empty;
    logic             at_boundary;

    assign fifo_empty = (fifo_level == '0);
    assign s_ready    = (fifo_level < FULL);
    assign push       = s_valid && s_ready;

    // Leaving PRIME is itself the first boundary, so the first strobe
    // follows the first buffered sample without a full period of delay.
    assign at_boundary = enable &&
                         (((state == PRIME) && !fifo_empty) ||
                          ((state == RUN) && (count == '0)));

    // Pop looks only at the registered level; a sample pushed on the
    // boundary cycle cannot satisfy that boundary.
    assign pop = at_boundary && !fifo_empty;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (enable) begin
                    state_nxt = PRIME;
                end
            end
            PRIME: begin
                if (!enable) begin
                    state_nxt = IDLE;
                end else if (!fifo_empty) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (!enable) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            count <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                PRIME: begin
                    if (at_boundary) begin
                        count <= RELOAD;
                    end else begin
                        count <= '0;
                    end
                end
                RUN: begin
                    if (!enable) begin
                        count <= '0;
                    end else if (count == '0) begin
                        count <= RELOAD;
                    end else begin
                        count <= count - CNT_W'(1);
                    end
                end
                default: count <= '0;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= s_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   fifo_level <= fifo_level + (AW + 1)'(1);
                2'b01:   fifo_level <= fifo_level - (AW + 1)'(1);
                default: fifo_level <= fifo_level;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sample       <= '0;
            sample_stb   <= 1'b0;
            underrun     <= 1'b0;
            sample_count <= '0;
        end else begin
            sample_stb <= at_boundary;
            if (at_boundary) begin
                sample_count <= sample_count + 16'd1;
                if (pop) begin
                    sample <= mem[rd_ptr];
                end else begin
                    underrun <= 1'b1;
`ifdef FIR_FEEDER_HOLD_ON_UNDERRUN_EN
                    sample   <= sample;
`else
                    sample   <= '0;
`endif
                end
            end
        end
    end

endmodule
